uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
// Shares the simpleuart transmit data register between NREQ byte requesters and owns its divider configuration.
// Programs the divider after reset and on request, then grants the UART round-robin.
// A requester keeps ownership from its first byte until its req_last byte, so packets never interleave.
// Sits between the requester blocks and the simpleuart reg_div_* / reg_dat_* register ports.
// PARAMETERS
// NREQ      3   number of requesters (1..8)
// DIV_INIT  48  divider written after reset (48 = 250000 baud @ 12 MHz); 0 = no write after reset
// PORTS
// clk            in   1       system clock
// reset          in   1       synchronous, active-high reset
// req_valid      in   NREQ    requester i has a byte; held until req_ready[i]
// req_data       in   8*NREQ  byte of requester i in bits [8i+7:8i]; stable while valid
// req_last       in   NREQ    byte i is the last byte of its packet (releases lock)
// req_ready      out  NREQ    one-hot; byte of requester i accepted this cycle
// grant          out  NREQ    one-hot current owner; 0 when none
// busy           out  1       transfer in flight or packet lock held
// div_set        in   1       one-cycle request to load div_value into the UART
// div_value      in   32      new divider value, sampled when div_set=1
// uart_div_we    out  4       to simpleuart reg_div_we
// uart_div_di    out  32      to simpleuart reg_div_di
// uart_dat_we    out  1       to simpleuart reg_dat_we
// uart_dat_di    out  32      to simpleuart reg_dat_di, {24'b0, byte}
// uart_dat_wait  in   1       from simpleuart reg_dat_wait
// BEHAVIOUR
// - Reset (sync, active-high) forces every output to 0, state INIT, rr pointer 0, lock 0, pending-div 0.
//   - Applies mid-transfer too: uart_dat_we is 0 from the next edge and the byte is dropped (no req_ready).
// - States: INIT -> IDLE -> SEND -> IDLE; IDLE -> DIV -> IDLE.
// - INIT: lasts 1 cycle.
//   - DIV_INIT!=0: uart_div_we=4'b1111, uart_div_di=DIV_INIT.
//   - DIV_INIT==0: nothing is driven.
//   - Next state is IDLE.
// - div_set: latches div_value into pending-div on any cycle; a later div_set overwrites it.
// - DIV: 1 cycle, uart_div_we=4'b1111, uart_div_di=pending; clears pending. Entered from IDLE only.
// - IDLE priority:
//   1. Pending divider, only if lock=0; it beats every request.
//   2. Otherwise, lock=1: wait for req_valid[owner] only; all others are ignored.
//   3. Otherwise, the first i with req_valid[i], scanning ptr, ptr+1, ... mod NREQ.
// - On a grant from IDLE:
//   - req_data[i] is latched into uart_dat_di and grant=onehot(i).
//   - SEND starts the next cycle.
// - SEND: uart_dat_we=1 and the latched byte is held.
//   - Accept = the cycle with uart_dat_wait==0; there is no timeout.
//   - On accept, req_ready[owner]=1 combinationally in that cycle, and next state is IDLE.
//   - uart_dat_we=0 for at least the one IDLE cycle after accept.
// - After accept with req_last[owner]=1: lock=0, ptr=(owner+1) mod NREQ, grant=0.
// - After accept with req_last[owner]=0: lock=1 and grant is held.
// - req_valid dropping during SEND is a protocol violation. The latched byte is still sent and req_ready still pulses.
// - busy = (state==SEND) | lock.
// - uart_div_we and uart_dat_we are never both 1.
// - uart_dat_di[31:8]=0 at all times.
// - Throughput: at most one byte per 2 cycles, plus the UART frame time signalled by uart_dat_wait.
// TESTING
// T1 reset 2 clk, release -> one cycle uart_div_we=4'hF, di=48; then all UART outputs 0, grant=0.
// T2 bench UART model (wait high 500 clk after accept); req0 sends 0x13, last=1 -> dat_we held;
//    dat_di=0x13; req_ready[0] pulses once, on the first wait=0 cycle; ser_tx frame 0-11001000-1.
// T3 req0,req1,req2 all valid, single-byte packets -> grant order 0,1,2,0; one ready pulse each.
// T4 req1 sends 3-byte packet (last on byte 3) while req0 valid throughout -> bytes 1a,1b,1c, then req0.
// T5 div_set=1, div_value=0x30 during req1 packet -> divider written only after req1 last byte.
//    Write happens before the next grant; div_we and dat_we never overlap.
// T6 reset asserted mid-SEND -> dat_we 0 next edge, no req_ready, INIT divider write repeats, ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the simpleuart transmit data register between NREQ
// byte requesters and owns the UART divider configuration.
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   req_valid/data/last     per-requester byte offer (data byte i at [8i+7:8i])
//   req_ready               one-hot, byte of the owner accepted this cycle
//   grant                   one-hot current owner, 0 when none
//   busy                    transfer in flight or packet lock held
//   div_set, div_value      request to load a new divider value
//   uart_div_we/di          to simpleuart reg_div_*
//   uart_dat_we/di/wait     to/from simpleuart reg_dat_*
module uart_tx_arbiter #(
    parameter int unsigned NREQ     = 3,
    parameter logic [31:0] DIV_INIT = 32'd48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    input  logic              div_set,
    input  logic [31:0]       div_value,
    output logic [3:0]        uart_div_we,
    output logic [31:0]       uart_div_di,
    output logic              uart_dat_we,
    output logic [31:0]       uart_dat_di,
    input  logic              uart_dat_wait
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SEND, ST_DIV} state_t;

    state_t           state;
    logic             lock;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic             pend_vld;
    logic [31:0]      pend_div;
    logic [7:0]       dat_byte;

    logic             scan_hit;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] sel_idx;
    logic [7:0]       sel_byte;
    logic             grant_now;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input int unsigned k);
        int unsigned s;
        s = 32'(a) + k;
        return IDX_W'(s % NREQ);
    endfunction

    assign uart_dat_di = {24'b0, dat_byte};

    // Accept handshake is combinational; a reset cycle never acknowledges the byte.
    assign req_ready = (state == ST_SEND && !uart_dat_wait && !reset) ? grant : '0;

    // Round-robin scan starting at ptr.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = ptr;
        cand     = ptr;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = wrap_add(ptr, k);
            if (!scan_hit && req_valid[cand]) begin
                scan_hit = 1'b1;
                scan_idx = cand;
            end
        end
    end

    // While a packet lock is held only the owner may be granted.
    always_comb begin
        sel_idx   = lock ? owner : scan_idx;
        grant_now = lock ? req_valid[owner] : scan_hit;
        sel_byte  = 8'h00;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_byte = req_data[8*i +: 8];
            end
        end
    end

    // Arbiter FSM; outputs are registered on entry to the state that presents them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            lock        <= 1'b0;
            ptr         <= '0;
            owner       <= '0;
            pend_vld    <= 1'b0;
            pend_div    <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            uart_div_we <= '0;
            uart_div_di <= '0;
            uart_dat_we <= 1'b0;
            dat_byte    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (DIV_INIT != 32'd0) begin
                        uart_div_we <= 4'hF;
                        uart_div_di <= DIV_INIT;
                    end
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    uart_div_we <= '0;
                    uart_div_di <= '0;
                    if (!lock && pend_vld) begin
                        state       <= ST_DIV;
                        uart_div_we <= 4'hF;
                        uart_div_di <= pend_div;
                        pend_vld    <= 1'b0;
                    end else if (grant_now) begin
                        state       <= ST_SEND;
                        owner       <= sel_idx;
                        grant       <= NREQ'(1) << sel_idx;
                        dat_byte    <= sel_byte;
                        uart_dat_we <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (!uart_dat_wait) begin
                        uart_dat_we <= 1'b0;
                        state       <= ST_IDLE;
                        if (req_last[owner]) begin
                            lock  <= 1'b0;
                            busy  <= 1'b0;
                            grant <= '0;
                            ptr   <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
                        end else begin
                            lock <= 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    uart_div_we <= '0;
                    uart_div_di <= '0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
            // A new request overrides the clear done when DIV consumes the old one.
            if (div_set) begin
                pend_vld <= 1'b1;
                pend_div <= div_value;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized bench for uart_tx_arbiter with a
// packet-level round-robin reference model and a simple UART busy model.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ  = 3;
    localparam int          BOUND = 4000;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              div_set;
    logic [31:0]       div_value;
    logic [3:0]        uart_div_we;
    logic [31:0]       uart_div_di;
    logic              uart_dat_we;
    logic [31:0]       uart_dat_di;
    logic              uart_dat_wait;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int wait_len = 0;
    int viol = 0;
    int ready_cnt = 0;
    int we_cnt = 0;
    int mptr = 0;
    int mon_owner = 0;
    int acc_i = 0;
    bit mon_lock = 0;
    bit prev_acc = 0;
    bit acc_now = 0;

    logic [8:0]  rq [NREQ][$];
    logic [8:0]  mq [NREQ][$];
    int          acc_idx[$];
    logic [7:0]  acc_dat[$];
    int          acc_cyc[$];
    logic [31:0] div_val[$];
    int          div_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART frame in progress holds off the data write.
    assign uart_dat_wait = uart_dat_we && (busy_cnt != 0);

    uart_tx_arbiter #(.NREQ(NREQ), .DIV_INIT(32'd48)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant), .busy(busy),
        .div_set(div_set), .div_value(div_value),
        .uart_div_we(uart_div_we), .uart_div_di(uart_div_di),
        .uart_dat_we(uart_dat_we), .uart_dat_di(uart_dat_di),
        .uart_dat_wait(uart_dat_wait)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [8*NREQ-1:0] v;
        v = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (rq[i].size() != 0);
            req_last[i]  = (rq[i].size() != 0) ? rq[i][0][8] : 1'b0;
            if (rq[i].size() != 0)
                v = v | ((8*NREQ)'(rq[i][0][7:0]) << (8 * i));
        end
        req_data = v;
    endtask

    function automatic bit rq_empty();
        for (int i = 0; i < NREQ; i++)
            if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_logs();
        acc_idx.delete(); acc_dat.delete(); acc_cyc.delete();
        div_val.delete(); div_cyc.delete();
        ready_cnt = 0;
        we_cnt    = 0;
    endtask

    // Observe one cycle mid-period, then apply the requester/UART response after the edge.
    task automatic tick();
        bit acc;
        int idx;
        @(negedge clk);
        acc     = uart_dat_we && !uart_dat_wait && !reset;
        acc_now = 1'b0;
        if (uart_dat_di[31:8] != 24'h0) viol++;
        if (uart_div_we != 4'h0 && uart_dat_we) viol++;
        if (req_ready !== (acc ? grant : '0)) viol++;
        if (busy !== (uart_dat_we | mon_lock)) viol++;
        if (prev_acc && uart_dat_we) viol++;
        if (uart_div_we != 4'h0) begin
            if (uart_div_we != 4'hF || mon_lock) viol++;
            div_val.push_back(uart_div_di);
            div_cyc.push_back(cyc);
        end
        if (acc) begin
            idx = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
            if (!$onehot(req_ready)) viol++;
            if (mon_lock && idx != mon_owner) viol++;
            acc_idx.push_back(idx);
            acc_dat.push_back(uart_dat_di[7:0]);
            acc_cyc.push_back(cyc);
            acc_now = 1'b1;
            acc_i   = idx;
        end
        prev_acc  = acc;
        if (uart_dat_we) we_cnt++;
        ready_cnt += $countones(req_ready);
        @(posedge clk);
        #1;
        if (reset) mon_lock = 1'b0;
        if (acc_now) begin
            if (acc_i >= 0 && rq[acc_i].size() != 0) begin
                mon_lock  = !rq[acc_i][0][8];
                mon_owner = acc_i;
                void'(rq[acc_i].pop_front());
            end
            busy_cnt = wait_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        drive();
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        busy_cnt = 0;
        repeat (n) tick();
        reset = 1'b0;
        mptr  = 0;
    endtask

    // Drain all queued packets and compare against whole-packet round-robin order.
    task automatic run(input string tag, input int div_at, input logic [31:0] dval, input bit rand_div);
        int exp_i[$];
        logic [7:0] exp_d[$];
        logic [31:0] last_set;
        bit did_set;
        bit fin;
        bit last;
        bit fire;
        int sel;
        int budget;
        int j;
        for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
        fin = 1'b0;
        while (!fin) begin
            sel = -1;
            for (int k = 0; k < NREQ; k++) begin
                j = (mptr + k) % NREQ;
                if (sel < 0 && mq[j].size() != 0) sel = j;
            end
            if (sel < 0) begin
                fin = 1'b1;
            end else begin
                last = 1'b0;
                while (!last && mq[sel].size() != 0) begin
                    last = mq[sel][0][8];
                    exp_i.push_back(sel);
                    exp_d.push_back(mq[sel][0][7:0]);
                    void'(mq[sel].pop_front());
                end
                mptr = (sel + 1) % NREQ;
            end
        end
        clear_logs();
        did_set  = 1'b0;
        last_set = '0;
        budget   = 0;
        drive();
        while (!rq_empty() && budget < BOUND) begin
            fire = 1'b0;
            if (div_at >= 0 && !did_set && acc_idx.size() == div_at) fire = 1'b1;
            if (rand_div && $urandom_range(0, 29) == 0) fire = 1'b1;
            if (fire) begin
                div_value = (div_at >= 0) ? dval : $urandom;
                last_set  = div_value;
                did_set   = 1'b1;
                div_set   = 1'b1;
                tick();
                div_set   = 1'b0;
            end else begin
                tick();
            end
            budget++;
        end
        repeat (6) tick();
        chk($sformatf("%s_done", tag), 32'(budget < BOUND), 1);
        chk($sformatf("%s_count", tag), acc_idx.size(), exp_i.size());
        for (int b = 0; b < exp_i.size() && b < acc_idx.size(); b++) begin
            chk($sformatf("%s_idx%0d", tag, b), acc_idx[b], exp_i[b]);
            chk($sformatf("%s_dat%0d", tag, b), acc_dat[b], exp_d[b]);
        end
        if (did_set) begin
            chk($sformatf("%s_divlast", tag),
                (div_val.size() != 0) ? div_val[div_val.size()-1] : 32'hDEAD_BEEF, last_set);
        end
        chk($sformatf("%s_viol", tag), viol, 0);
    endtask

    initial begin
        int n;
        int len;
        reset     = 1'b1;
        div_set   = 1'b0;
        div_value = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        // T1: reset values and the post-reset divider write
        tick();
        tick();
        chk("rst_div_we", uart_div_we, 0);
        chk("rst_div_di", uart_div_di, 0);
        chk("rst_dat_we", uart_dat_we, 0);
        chk("rst_dat_di", uart_dat_di, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        viol = 0;
        clear_logs();
        reset = 1'b0;
        mptr  = 0;
        repeat (4) tick();
        chk("t1_div_writes", div_val.size(), 1);
        chk("t1_div_value", (div_val.size() != 0) ? div_val[0] : 32'h0, 48);
        chk("t1_div_we_after", uart_div_we, 0);
        chk("t1_div_di_after", uart_div_di, 0);
        chk("t1_dat_we_after", uart_dat_we, 0);
        chk("t1_grant_after", grant, 0);
        chk("t1_viol", viol, 0);

        // T2: single byte held against a busy UART
        clear_logs();
        wait_len = 500;
        busy_cnt = 30;
        rq[0].push_back(9'h113);
        drive();
        n = 0;
        while (acc_idx.size() == 0 && n < 100) begin tick(); n++; end
        chk("t2_accepted", acc_idx.size(), 1);
        chk("t2_idx", (acc_idx.size() != 0) ? acc_idx[0] : -1, 0);
        chk("t2_data", (acc_dat.size() != 0) ? acc_dat[0] : 8'h00, 8'h13);
        chk("t2_we_held", we_cnt, 30);
        repeat (4) tick();
        chk("t2_ready_once", ready_cnt, 1);
        chk("t2_we_after", uart_dat_we, 0);
        chk("t2_grant_after", grant, 0);
        chk("t2_busy_after", busy, 0);
        chk("t2_viol", viol, 0);
        mptr = 1;

        // T3: three single-byte requesters after reset
        do_reset(2);
        repeat (4) tick();
        wait_len = 4;
        rq[0].push_back(9'h1A0);
        rq[0].push_back(9'h1A3);
        rq[1].push_back(9'h1A1);
        rq[2].push_back(9'h1A2);
        run("t3", -1, 32'h0, 1'b0);
        chk("t3_ready_pulses", ready_cnt, 4);

        // T4: 3-byte packet is not interleaved by a waiting requester
        wait_len = 3;
        rq[1].push_back(9'h01A);
        rq[1].push_back(9'h01B);
        rq[1].push_back(9'h11C);
        rq[0].push_back(9'h10D);
        run("t4", -1, 32'h0, 1'b0);

        // T5: divider request during a locked packet waits for the last byte
        rq[1].push_back(9'h051);
        rq[1].push_back(9'h052);
        rq[1].push_back(9'h153);
        rq[0].push_back(9'h150);
        run("t5", 1, 32'h30, 1'b0);
        chk("t5_div_writes", div_val.size(), 1);
        chk("t5_div_value", (div_val.size() != 0) ? div_val[0] : 32'h0, 32'h30);
        if (div_cyc.size() != 0 && acc_cyc.size() == 4) begin
            chk("t5_div_after_last", 32'(div_cyc[0] > acc_cyc[2]), 1);
            chk("t5_div_before_next", 32'(div_cyc[0] < acc_cyc[3]), 1);
        end else begin
            chk("t5_div_timing_data", 32'(div_cyc.size()) + 32'(acc_cyc.size()), 5);
        end

        // T6: reset in the middle of a send
        clear_logs();
        busy_cnt = 50;
        rq[2].push_back(9'h166);
        drive();
        n = 0;
        while (!uart_dat_we && n < 20) begin tick(); n++; end
        chk("t6_send_started", uart_dat_we, 1);
        tick();
        tick();
        busy_cnt = 0;
        reset    = 1'b1;
        #3;
        chk("t6_no_ready_in_reset", req_ready, 0);
        tick();
        chk("t6_we_drop", uart_dat_we, 0);
        chk("t6_grant_drop", grant, 0);
        chk("t6_no_accept", acc_idx.size(), 0);
        tick();
        rq[0].push_back(9'h170);
        rq[1].push_back(9'h171);
        reset = 1'b0;
        mptr  = 0;
        wait_len = 2;
        run("t6", -1, 32'h0, 1'b0);
        chk("t6_div_writes", div_val.size(), 1);
        chk("t6_div_value", (div_val.size() != 0) ? div_val[0] : 32'h0, 48);

        // Randomized packet mixes with random divider requests
        for (int r = 0; r < 6; r++) begin
            wait_len = $urandom_range(0, 6);
            for (int i = 0; i < NREQ; i++) begin
                n = $urandom_range(0, 3);
                for (int p = 0; p < n; p++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++)
                        rq[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                end
            end
            run($sformatf("rnd%0d", r), -1, 32'h0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
